// File: rtl/mousetrap_pkg.sv
// mousetrap_pkg
//   Shared constants for the MOUSETRAP pipeline stage and its matched-delay
//   buffer.
//   MT_DATA_W_DEFAULT     : default bundled-data width
//   MT_DONE_DELAY_DEFAULT : default matched delay on the done event (cycles)
//   MT_DONE_DELAY_MAX     : largest supported matched delay (cycles)
//   mt_clamp_delay()      : folds a requested delay into 1..MT_DONE_DELAY_MAX
package mousetrap_pkg;

  localparam int unsigned MT_DATA_W_DEFAULT     = 8;
  localparam int unsigned MT_DONE_DELAY_DEFAULT = 2;
  localparam int unsigned MT_DONE_DELAY_MAX     = 64;

  function automatic int unsigned mt_clamp_delay(input int unsigned d);
    if (d < 1) begin
      return 1;
    end
    if (d > MT_DONE_DELAY_MAX) begin
      return MT_DONE_DELAY_MAX;
    end
    return d;
  endfunction

endpackage

// File: rtl/mt_delay_line.sv
// mt_delay_line
//   Matched-delay buffer for two-phase handshake wires: a DELAY-stage shift
//   register that clears to 0 on asynchronous active-low reset.
//   Ports:
//     clk  : clock, shifts on rising edge
//     rstn : asynchronous active-low reset, clears every stage
//     din  : wire to delay
//     dout : din delayed by DELAY cycles
//   Parameter DELAY must be at least 1.
module mt_delay_line #(
  parameter int unsigned DELAY = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout
);

  logic [DELAY-1:0] sr;

  // Stage-by-stage loop rather than a concatenated shift so DELAY=1 elaborates
  // without a zero-width slice.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int unsigned i = 1; i < DELAY; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[DELAY-1];

endmodule

// File: rtl/mousetrap_stage.sv
// mousetrap_stage
//   Clocked MOUSETRAP-style two-phase pipeline stage. A one-bit done register
//   and a DATA_W data register share a local enable en = XNOR(done, ackN):
//   the stage is open once downstream has acknowledged its last event.
//   Ports:
//     clk     : clock, all state updates on the rising edge
//     rstn    : asynchronous active-low reset
//     reqN    : two-phase request from upstream (one toggle per event)
//     ackN    : two-phase acknowledge from downstream
//     datain  : bundled data, valid when reqN toggles
//     doneN   : two-phase request to downstream
//     ackNm1  : two-phase acknowledge to upstream (same as doneN)
//     dataout : captured data
//   Build option MOUSETRAP_DONE_DELAY_EN: doneN/ackNm1 come from a
//   DONE_DELAY-cycle mt_delay_line on the done register; otherwise DONE_DELAY
//   is ignored.
module mousetrap_stage
  import mousetrap_pkg::*;
#(
  parameter int unsigned DATA_W     = MT_DATA_W_DEFAULT,
  parameter int unsigned DONE_DELAY = MT_DONE_DELAY_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              reqN,
  input  logic              ackN,
  input  logic [DATA_W-1:0] datain,
  output logic              doneN,
  output logic              ackNm1,
  output logic [DATA_W-1:0] dataout
);

  logic              done_q;
  logic [DATA_W-1:0] data_q;
  logic              en;

  // Enable always tracks the undelayed done so the stage reopens as soon as
  // the acknowledge for its own latest capture arrives.
  assign en = ~(done_q ^ ackN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_q <= 1'b0;
      data_q <= '0;
    end else if (en) begin
      done_q <= reqN;
      data_q <= datain;
    end
  end

`ifdef MOUSETRAP_DONE_DELAY_EN
  localparam int unsigned DLY = mt_clamp_delay(DONE_DELAY);

  logic done_dly;

  mt_delay_line #(
    .DELAY(DLY)
  ) u_done_dly (
    .clk (clk),
    .rstn(rstn),
    .din (done_q),
    .dout(done_dly)
  );

  assign doneN = done_dly;
`else
  logic unused_done_delay;
  assign unused_done_delay = (DONE_DELAY != 0);

  assign doneN = done_q;
`endif

  assign ackNm1  = doneN;
  assign dataout = data_q;

endmodule

// File: tb/tb_mousetrap_stage.sv
// tb_mousetrap_stage
//   Randomized and directed bench for mousetrap_stage. Every upstream event
//   pushes its data into a queue; a monitor pops one entry per doneN toggle.
module tb_mousetrap_stage;

  localparam int unsigned DW = 8;
`ifdef MOUSETRAP_DONE_DELAY_EN
  localparam int unsigned LAT = 4;
`else
  localparam int unsigned LAT = 1;
`endif

  logic          clk;
  logic          rstn;
  logic          reqN_drv;
  logic          ackN_drv;
  logic [DW-1:0] datain_drv;
  logic          ring_mode;

  logic          dut_reqN;
  logic          dut_ackN;
  logic [DW-1:0] dut_datain;
  logic          doneN;
  logic          ackNm1;
  logic [DW-1:0] dataout;
  logic          ring_d;

  int checks;
  int failures;
  logic [DW-1:0] exp_q[$];
  logic          prev_done;

  mousetrap_stage #(
    .DATA_W    (DW),
    .DONE_DELAY(3)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .reqN   (dut_reqN),
    .ackN   (dut_ackN),
    .datain (dut_datain),
    .doneN  (doneN),
    .ackNm1 (ackNm1),
    .dataout(dataout)
  );

  // Ring wiring: ack is doneN delayed by 2, req its inverse, data = dataout+4.
  mt_delay_line #(
    .DELAY(2)
  ) u_ring_dly (
    .clk (clk),
    .rstn(rstn),
    .din (doneN),
    .dout(ring_d)
  );

  assign dut_reqN   = ring_mode ? ~ring_d : reqN_drv;
  assign dut_ackN   = ring_mode ? ring_d : ackN_drv;
  assign dut_datain = ring_mode ? dataout + 8'd4 : datain_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: each doneN toggle outside reset is one output event.
  initial prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      prev_done = doneN;
    end else if (doneN !== prev_done) begin
      prev_done = doneN;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event actual=%0h required=none", dataout);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (dataout !== e) begin
          failures++;
          $display("FAIL event_data actual=%0h required=%0h", dataout, e);
        end
      end
      chk("ack_equals_done", ackNm1, doneN);
    end
  end

  task automatic wait_queue_le(input string name, input int n, input int budget);
    int cnt;
    cnt = 0;
    while (exp_q.size() > n && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    if (exp_q.size() > n) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, exp_q.size(), n);
    end
  endtask

  bit up_done;

  task automatic upstream(input int n);
    for (int i = 0; i < n; i++) begin
      int cnt;
      cnt = 0;
      while (ackNm1 !== reqN_drv && cnt < 200) begin
        tick();
        cnt++;
      end
      if (ackNm1 !== reqN_drv) begin
        failures++;
        $display("FAIL upstream_wait actual=%0b required=%0b", ackNm1, reqN_drv);
      end
      repeat ($urandom_range(0, 2)) tick();
      datain_drv = DW'($urandom);
      reqN_drv   = ~reqN_drv;
      exp_q.push_back(datain_drv);
      tick();
    end
    up_done = 1'b1;
  endtask

  task automatic downstream();
    int cnt;
    cnt = 0;
    while (!(up_done && ackN_drv === doneN && exp_q.size() == 0) && cnt < 5000) begin
      tick();
      cnt++;
      if (ackN_drv !== doneN && $urandom_range(0, 2) == 0) begin
        ackN_drv = doneN;
      end
    end
    if (cnt >= 5000) begin
      failures++;
      $display("FAIL random_phase_timeout actual=%0d required=0", exp_q.size());
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    up_done    = 1'b0;
    ring_mode  = 1'b0;
    rstn       = 1'b0;
    reqN_drv   = 1'b1;
    ackN_drv   = 1'b0;
    datain_drv = 8'hAA;

    // Reset holds outputs low even with reqN=1.
    repeat (2) @(negedge clk);
    chk("reset_doneN", doneN, 1'b0);
    chk("reset_ackNm1", ackNm1, 1'b0);
    chk("reset_dataout", dataout, 8'h00);

    exp_q.push_back(8'hAA);
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("release_pre_capture", doneN, 1'b0);
    repeat (LAT) @(negedge clk);
    chk("release_capture_done", doneN, 1'b1);
    chk("release_capture_data", dataout, 8'hAA);

    // Second reset to start from done=0 for the single-event test.
    tick();
    rstn       = 1'b0;
    reqN_drv   = 1'b0;
    ackN_drv   = 1'b0;
    datain_drv = 8'h00;
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    reqN_drv   = 1'b1;
    datain_drv = 8'h12;
    exp_q.push_back(8'h12);
    @(negedge clk);
    chk("single_pre_edge", doneN, 1'b0);
    repeat (LAT) @(negedge clk);
    chk("single_doneN", doneN, 1'b1);
    chk("single_ackNm1", ackNm1, 1'b1);
    chk("single_dataout", dataout, 8'h12);

    // Backpressure: ackN held low, new event stays pending.
    tick();
    reqN_drv   = 1'b0;
    datain_drv = 8'h34;
    exp_q.push_back(8'h34);
    repeat (3) @(negedge clk);
    chk("bp_hold_data", dataout, 8'h12);
    chk("bp_hold_done", doneN, 1'b1);
    tick();
    ackN_drv = 1'b1;
    @(negedge clk);
    chk("bp_pre_open", doneN, 1'b1);
    repeat (LAT) @(negedge clk);
    chk("bp_release_done", doneN, 1'b0);
    chk("bp_release_data", dataout, 8'h34);

    // Random two-phase traffic from both sides.
    fork
      upstream(40);
      downstream();
    join
    wait_queue_le("random_drain", 0, 200);

    // Ring counter: 4, 8, ..., 252, 0, 4, ...
    tick();
    rstn      = 1'b0;
    ring_mode = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      exp_q.push_back(DW'(4 * i));
    end
    repeat (2) tick();
    rstn = 1'b1;
    wait_queue_le("ring_run", 5, 2000);

    // Asynchronous reset mid-ring, away from any clock edge.
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("midreset_doneN", doneN, 1'b0);
    chk("midreset_ackNm1", ackNm1, 1'b0);
    chk("midreset_dataout", dataout, 8'h00);
    exp_q.delete();
    repeat (2) tick();
    for (int i = 1; i <= 10; i++) begin
      exp_q.push_back(DW'(4 * i));
    end
    rstn = 1'b1;
    wait_queue_le("ring_restart", 0, 500);
    rstn      = 1'b0;
    ring_mode = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
